// File: rtl/param_mdu_if.sv
// -----------------------------------------------------------------------------
// param_mdu_if
//   Bundles the request/response signals of the multiply/divide unit.
//
//   Handshake: start is the request valid and !busy is the ready. A request
//   transfers on a rising clk edge where start=1, busy=0 and cancel=0; op,
//   in_a and in_b are sampled on that same edge. cancel is a flush: it blocks
//   a transfer and aborts an operation already in flight.
//
//   Signals
//     start   requester -> unit  request valid
//     op      requester -> unit  operation code (4 bits)
//     in_a    requester -> unit  operand A (dividend / MTHI / MTLO source)
//     in_b    requester -> unit  operand B (divisor)
//     cancel  requester -> unit  flush
//     busy    unit -> requester  multi-cycle operation in flight
//     done    unit -> requester  one-cycle pulse: HI/LO show a new result
//     hi, lo  unit -> requester  architectural HI/LO registers
// -----------------------------------------------------------------------------
interface param_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in_a, in_b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in_a, in_b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/param_mdu.sv
// -----------------------------------------------------------------------------
// param_mdu
//   Multiply/divide unit with architectural HI/LO registers.
//     MULT/MULTU : {HI,LO} = A * B after MUL_LAT cycles
//     DIV/DIVU   : restoring divider on magnitudes, WIDTH cycles + 1 fix-up
//                  cycle; LO = quotient, HI = remainder
//     MTHI/MTLO  : single-edge write of in_a, no busy, no done
//     MADD(U)/MSUB(U) : {HI,LO} +/- A * B, only when PARAM_MDU_MACC_EN is
//                  defined; otherwise those codes are no-ops.
//
//   Parameters
//     WIDTH    operand and HI/LO width (8..64)
//     MUL_LAT  multiply latency in cycles (1..15)
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     bus        param_mdu_if slave modport (request/response signals)
//     dbg_state  current FSM state (IDLE=0, MUL=1, DIV=2, FIX=3)
//
//   Configuration macro: PARAM_MDU_MACC_EN enables the accumulate ops.
// -----------------------------------------------------------------------------
module param_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  param_mdu_if.slave  bus,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  // Wide enough for WIDTH-1 (max 63) and MUL_LAT-1 (max 14).
  localparam int CW = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] o);
    logic r;
    r = (o == OP_MULT) || (o == OP_MULTU);
`ifdef PARAM_MDU_MACC_EN
    r = r || (o == OP_MADD) || (o == OP_MADDU) ||
         (o == OP_MSUB) || (o == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;     // raw operands, held for the whole op
  logic [WIDTH-1:0]   bmag_q;       // divisor magnitude
  logic [WIDTH-1:0]   quo_q;        // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   rem_q;        // partial remainder (always < bmag_q)
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // ---------------------------------------------------------------------------
  // FSM control
  // ---------------------------------------------------------------------------
  logic accept;      // any request transfers this edge
  logic start_mul;
  logic start_div;
  logic mul_fin;     // multiply result written this edge
  logic div_step;    // one quotient bit produced this edge
  logic fix_fin;     // divide result written this edge

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    mul_fin   = 1'b0;
    div_step  = 1'b0;
    fix_fin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept = bus.start && !bus.cancel;
        if (accept && is_mul_op(bus.op)) begin
          start_mul = 1'b1;
          state_d   = S_MUL;
        end else if (accept && is_div_op(bus.op)) begin
          start_div = 1'b1;
          state_d   = S_DIV;
        end
      end
      S_MUL: begin
        // cancel beats completion on the same edge
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          mul_fin = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.cancel) fix_fin = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand magnitudes for the divider (only DIV treats operands as signed)
  // ---------------------------------------------------------------------------
  logic             in_signed_div;
  logic [WIDTH-1:0] abs_a_in, abs_b_in;

  always_comb begin
    in_signed_div = (bus.op == OP_DIV);
    abs_a_in = (in_signed_div && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    abs_b_in = (in_signed_div && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
  end

  // ---------------------------------------------------------------------------
  // Multiply datapath: extend both operands to 2*WIDTH so one multiplier
  // serves signed and unsigned; the low 2*WIDTH bits are exact in both cases.
  // ---------------------------------------------------------------------------
  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;

  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ext_a = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;
  end

  always_comb begin
    mul_res = prod;
`ifdef PARAM_MDU_MACC_EN
    // accumulate against HI/LO as they stand at completion
    if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
      mul_res = {hi_q, lo_q} + prod;
    end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
      mul_res = {hi_q, lo_q} - prod;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Divide datapath: one restoring step per cycle. The shifted remainder needs
  // one extra bit; when it is >= divisor the low WIDTH bits of the difference
  // are exact because the new remainder is below the divisor.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub;
  logic             ge;

  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    sub    = rem_sh[WIDTH-1:0] - bmag_q;
    ge     = (rem_sh >= {1'b0, bmag_q});
  end

  // Sign fix-up. MIN / -1 needs no special case: the quotient magnitude
  // 2^(WIDTH-1) negates back to MIN and the remainder is zero.
  logic             div_signed, q_neg, r_neg;
  logic [WIDTH-1:0] div_hi, div_lo;

  always_comb begin
    div_signed = (op_q == OP_DIV);
    q_neg      = div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg      = div_signed && a_q[WIDTH-1];
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end else begin
      div_lo = q_neg ? -quo_q : quo_q;
      div_hi = r_neg ? -rem_q : rem_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bmag_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= mul_fin || fix_fin;

      if (start_mul || start_div) begin
        op_q   <= bus.op;
        a_q    <= bus.in_a;
        b_q    <= bus.in_b;
        bmag_q <= abs_b_in;
        quo_q  <= abs_a_in;
        rem_q  <= '0;
        cnt_q  <= start_div ? CW'(WIDTH - 1) : CW'(MUL_LAT - 1);
      end else if ((state_q == S_MUL || state_q == S_DIV) && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (accept && bus.op == OP_MTHI) hi_q <= bus.in_a;
      if (accept && bus.op == OP_MTLO) lo_q <= bus.in_a;

      if (div_step) begin
        quo_q <= {quo_q[WIDTH-2:0], ge};
        rem_q <= ge ? sub : rem_sh[WIDTH-1:0];
      end

      if (mul_fin) begin
        hi_q <= mul_res[2*WIDTH-1:WIDTH];
        lo_q <= mul_res[WIDTH-1:0];
      end

      if (fix_fin) begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_mdu.sv
// -----------------------------------------------------------------------------
// tb_param_mdu
//   Self-checking bench for param_mdu (WIDTH=32, MUL_LAT=5). A transaction
//   level model predicts HI/LO, busy and done every cycle; directed cases pin
//   hand-computed values, then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_param_mdu;
  localparam int W   = 32;
  localparam int LAT = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  param_mdu_if #(.WIDTH(W)) bus ();

  param_mdu #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a pending result with the cycle it is due
  // ---------------------------------------------------------------------------
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic           m_pend = 1'b0;
  logic           m_done = 1'b0;
  int             m_kind = 0;        // 0 write, 1 accumulate, 2 subtract
  logic [2*W-1:0] m_res = '0;
  longint         cyc = 0, m_due = 0;
  int             m_dones = 0;
  logic [2*W-1:0] exp_q[$];

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // returns {hi, lo}
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction

  initial begin
    logic [63:0] acc, res;
    logic [31:0] a, b;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_hi = '0; m_lo = '0; m_pend = 1'b0; m_done = 1'b0;
        exp_q.delete();
      end else begin
        cyc++;
        m_done = 1'b0;
        if (m_pend) begin
          if (bus.cancel) begin
            m_pend = 1'b0;
          end else if (cyc == m_due) begin
            acc = {m_hi, m_lo};
            case (m_kind)
              0:       res = m_res;
              1:       res = acc + m_res;
              default: res = acc - m_res;
            endcase
            {m_hi, m_lo} = res;
            m_done = 1'b1;
            m_dones++;
            exp_q.push_back(res);
            m_pend = 1'b0;
          end
        end else if (bus.start && !bus.cancel) begin
          a = bus.in_a;
          b = bus.in_b;
          case (bus.op)
            4'd1, 4'd2: begin
              m_res = mul_model(a, b, bus.op == 4'd1);
              m_kind = 0; m_pend = 1'b1; m_due = cyc + LAT;
            end
            4'd3, 4'd4: begin
              m_res = div_model(a, b, bus.op == 4'd3);
              m_kind = 0; m_pend = 1'b1; m_due = cyc + W + 1;
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
`ifdef PARAM_MDU_MACC_EN
            4'd9, 4'd10: begin
              m_res = mul_model(a, b, bus.op == 4'd9);
              m_kind = 1; m_pend = 1'b1; m_due = cyc + LAT;
            end
            4'd11, 4'd12: begin
              m_res = mul_model(a, b, bus.op == 4'd11);
              m_kind = 2; m_pend = 1'b1; m_due = cyc + LAT;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: compare every cycle, away from the active edge
  // ---------------------------------------------------------------------------
  int dut_dones = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("busy", bus.busy, m_pend);
      chk("done", bus.done, m_done);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      if (bus.done) begin
        dut_dones++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_result: got done pulse expected none queued at %0t", $time);
        end else begin
          chk("done_result", {bus.hi, bus.lo}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 10));
      4:       return -32'($urandom_range(1, 10));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, scramble the inputs afterwards, then follow it to the
  // end counting busy cycles and done pulses (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output int dones);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'($urandom); bus.in_a = $urandom; bus.in_b = $urandom;
    bcyc = 0;
    dones = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy) bcyc++;
      if (bus.done) dones++;
      if (!bus.busy) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 100 && bus.busy; k++) @(negedge clk);
    chk(name, bus.busy, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int bc, dn, cnt;
    bus.start = 1'b0; bus.op = '0; bus.in_a = '0; bus.in_b = '0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_state", dbg_state, 2'd0);

    // MULT -2 * 3
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, bc, dn);
    chk("mult_busy_cycles", bc, 5);
    chk("mult_dones", dn, 1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // MULTU max * max
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);

    // DIV -7 / 2
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, bc, dn);
    chk("div_busy_cycles", bc, 33);
    chk("div_dones", dn, 1);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    // DIVU 7 / 0
    run_op(4'd4, 32'd7, 32'd0, bc, dn);
    chk("div0_busy_cycles", bc, 33);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'd7);

    // DIV MIN / -1
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, dn);
    chk("divmin_lo", bus.lo, 32'h8000_0000);
    chk("divmin_hi", bus.hi, 32'h0);

    // MTHI: single edge, no busy, no done
    run_op(4'd7, 32'hAAAA_5555, 32'd0, bc, dn);
    chk("mthi_busy_cycles", bc, 0);
    chk("mthi_dones", dn, 0);
    chk("mthi_hi", bus.hi, 32'hAAAA_5555);

`ifdef PARAM_MDU_MACC_EN
    run_op(4'd7, 32'd0, 32'd0, bc, dn);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd0, bc, dn);
    run_op(4'd10, 32'd1, 32'd1, bc, dn);
    chk("maddu_dones", dn, 1);
    chk("maddu_hi", bus.hi, 32'd1);
    chk("maddu_lo", bus.lo, 32'd0);
    run_op(4'd7, 32'd0, 32'd0, bc, dn);
    run_op(4'd8, 32'd0, 32'd0, bc, dn);
    run_op(4'd12, 32'd1, 32'd1, bc, dn);
    chk("msubu_hi", bus.hi, 32'hFFFF_FFFF);
    chk("msubu_lo", bus.lo, 32'hFFFF_FFFF);
`else
    run_op(4'd7, 32'd5, 32'd0, bc, dn);
    run_op(4'd10, 32'd1, 32'd1, bc, dn);
    chk("maddu_off_busy", bc, 0);
    chk("maddu_off_dones", dn, 0);
    chk("maddu_off_hi", bus.hi, 32'd5);
`endif

    // Cancel in cycle 10 of a DIV
    run_op(4'd7, 32'h11, 32'd0, bc, dn);
    run_op(4'd8, 32'h22, 32'd0, bc, dn);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd3; bus.in_a = 32'd100; bus.in_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy", bus.busy, 1'b0);
    chk("cancel_done", bus.done, 1'b0);
    chk("cancel_hi", bus.hi, 32'h11);
    chk("cancel_lo", bus.lo, 32'h22);
    @(negedge clk);
    chk("cancel_done_after", bus.done, 1'b0);
    run_op(4'd8, 32'h1234, 32'd0, bc, dn);
    chk("mtlo_after_cancel", bus.lo, 32'h1234);

    // start held while busy: exactly one operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd1; bus.in_a = 32'd7; bus.in_b = 32'd9;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.done) cnt++;
      if (k == 3) bus.start = 1'b0;
    end
    chk("held_start_dones", cnt, 1);
    chk("held_start_lo", bus.lo, 32'd63);

    // Reset in the middle of a MULT
    run_op(4'd7, 32'hDEAD, 32'd0, bc, dn);
    run_op(4'd8, 32'hBEEF, 32'd0, bc, dn);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd1; bus.in_a = 32'd3; bus.in_b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    chk("midrst_busy", bus.busy, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("postrst_busy", bus.busy, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.op     = 4'($urandom_range(0, 15));
      bus.in_a   = rand_val();
      bus.in_b   = rand_val();
      bus.cancel = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    wait_idle("final_idle");
    @(negedge clk);
    chk("done_count", dut_dones, m_dones);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
